chain_manager: RTL and testbench

Packet-queue bookkeeping block for the shared-SRAM switch buffer. Keeps a pool of 64 packet descriptor slots and links them into 128 output queues, one per {dest_port, priority}, through a shared next-pointer array `chain`. A write enqueues one packet descriptor; a read dequeues the head of a selected queue and returns its slot to a FIFO free list.

---
 rtl/chain_pkg.sv | 20 ++
 rtl/chain_manager_queue_table.sv | 67 ++++++
 rtl/chain_manager.sv | 142 ++++++++++++++
 tb/tb_chain_manager.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// chain_pkg: shared constants, types and helpers for the packet-queue
// bookkeeping block (chain_manager and its queue_table).
//   NUM_SLOTS  - descriptor slots in the pool (slot index = buffer handle)
//   NUM_QUEUES - output queues, 16 ports x 8 priorities
//   SLOT_W     - slot index width
//   slot_t     - slot index
//   qidx_t     - queue index {dest_port, priority}
//   qidx()     - builds a queue index from port and priority
package chain_pkg;
    localparam int NUM_SLOTS  = 64;
    localparam int NUM_QUEUES = 128;
    localparam int SLOT_W     = 6;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [6:0]        qidx_t;

    function automatic qidx_t qidx(input logic [3:0] dest_port, input logic [2:0] prio);
        return {dest_port, prio};
    endfunction
endpackage

// File: rtl/chain_manager_queue_table.sv
// queue_table: per-queue head / tail / count register file.
// One enqueue port and one dequeue port per cycle; when both hit the same
// queue the updates are merged here.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   enq_i, enq_q_i         enqueue strobe and target queue
//   enq_slot_i             slot being appended
//   enq_num_o, enq_tail_o  current count / tail of the enqueue queue
//   deq_i, deq_q_i         dequeue strobe (already validated) and queue
//   deq_next_i             chain[] successor of the current head
//   deq_num_o, deq_head_o  current count / head of the dequeue queue
module queue_table
    import chain_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enq_i,
    input  qidx_t      enq_q_i,
    input  slot_t      enq_slot_i,
    output logic [6:0] enq_num_o,
    output slot_t      enq_tail_o,
    input  logic       deq_i,
    input  qidx_t      deq_q_i,
    input  slot_t      deq_next_i,
    output logic [6:0] deq_num_o,
    output slot_t      deq_head_o
);
    slot_t      head_q [NUM_QUEUES];
    slot_t      tail_q [NUM_QUEUES];
    logic [6:0] num_q  [NUM_QUEUES];

    assign enq_num_o  = num_q[enq_q_i];
    assign enq_tail_o = tail_q[enq_q_i];
    assign deq_num_o  = num_q[deq_q_i];
    assign deq_head_o = head_q[deq_q_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
                num_q[q]  <= '0;
            end
        end else if (enq_i && deq_i && (enq_q_i == deq_q_i)) begin
            // Same queue: count is unchanged. A single-entry queue is
            // replaced outright by the new slot.
            if (num_q[deq_q_i] == 7'd1) begin
                head_q[deq_q_i] <= enq_slot_i;
            end else begin
                head_q[deq_q_i] <= deq_next_i;
            end
            tail_q[enq_q_i] <= enq_slot_i;
        end else begin
            if (deq_i) begin
                head_q[deq_q_i] <= deq_next_i;
                num_q[deq_q_i]  <= num_q[deq_q_i] - 7'd1;
            end
            if (enq_i) begin
                if (num_q[enq_q_i] == 7'd0) begin
                    head_q[enq_q_i] <= enq_slot_i;
                end
                tail_q[enq_q_i] <= enq_slot_i;
                num_q[enq_q_i]  <= num_q[enq_q_i] + 7'd1;
            end
        end
    end
endmodule

// File: rtl/chain_manager.sv
// chain_manager: packet descriptor pool linked into 128 output queues via a
// shared next-pointer array, with a FIFO free list.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   wea_i, w_size_i               enqueue request and packet size
//   priority_i, dest_port_i       queue select for enqueue
//   rea_i, out_port_i             dequeue request; out_port_i[7] must be 0
//   w_ack_o, w_slot_o, w_drop_o   enqueue result (pulses, slot held)
//   r_valid_o, r_slot_o, r_size_o dequeue result (pulse, slot/size held)
//   r_empty_o                     dequeue of empty/invalid queue (pulse)
//   free_cnt_o                    free slot count
module chain_manager
    import chain_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wea_i,
    input  logic [7:0] w_size_i,
    input  logic [2:0] priority_i,
    input  logic [3:0] dest_port_i,
    input  logic       rea_i,
    input  logic [7:0] out_port_i,
    output logic       w_ack_o,
    output logic [5:0] w_slot_o,
    output logic       w_drop_o,
    output logic       r_valid_o,
    output logic [5:0] r_slot_o,
    output logic [7:0] r_size_o,
    output logic       r_empty_o,
    output logic [6:0] free_cnt_o
);
    slot_t      chain_q  [NUM_SLOTS];
    logic [7:0] size_mem [NUM_SLOTS];

    slot_t      free_head_q, free_head_d;
    slot_t      free_tail_q, free_tail_d;
    logic [6:0] free_cnt_q, free_cnt_d, cnt_left;

    qidx_t      enq_q, deq_q;
    logic [6:0] enq_num, deq_num;
    slot_t      enq_tail, deq_head;
    logic       alloc, drop, rd_ok, rd_empty, same_one, link_en, free_link_en;

    queue_table u_qt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enq_i      (alloc),
        .enq_q_i    (enq_q),
        .enq_slot_i (free_head_q),
        .enq_num_o  (enq_num),
        .enq_tail_o (enq_tail),
        .deq_i      (rd_ok),
        .deq_q_i    (deq_q),
        .deq_next_i (chain_q[deq_head]),
        .deq_num_o  (deq_num),
        .deq_head_o (deq_head)
    );

    always_comb begin
        enq_q        = qidx(dest_port_i, priority_i);
        deq_q        = out_port_i[6:0];
        alloc        = wea_i && (free_cnt_q != 7'd0);
        drop         = wea_i && (free_cnt_q == 7'd0);
        rd_ok        = rea_i && !out_port_i[7] && (deq_num != 7'd0);
        rd_empty     = rea_i && !rd_ok;
        // The slot being dequeued is the old tail here, so no link is needed.
        same_one     = alloc && rd_ok && (enq_q == deq_q) && (enq_num == 7'd1);
        link_en      = alloc && (enq_num != 7'd0) && !same_one;
        cnt_left     = free_cnt_q - {6'd0, alloc};
        free_head_d  = free_head_q;
        free_tail_d  = free_tail_q;
        free_link_en = 1'b0;
        if (alloc) begin
            free_head_d = chain_q[free_head_q];
        end
        if (rd_ok) begin
            if (cnt_left == 7'd0) begin
                free_head_d = deq_head;
                free_tail_d = deq_head;
            end else begin
                free_link_en = 1'b1;
                free_tail_d  = deq_head;
            end
        end
        free_cnt_d = cnt_left + {6'd0, rd_ok};
    end

    // link_en and free_link_en never target the same entry: one is an
    // allocated tail, the other a free-list tail.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                chain_q[i] <= slot_t'(i + 1);
            end
        end else begin
            if (link_en) begin
                chain_q[enq_tail] <= free_head_q;
            end
            if (free_link_en) begin
                chain_q[free_tail_q] <= deq_head;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc && !rst_i) begin
            size_mem[free_head_q] <= w_size_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_head_q <= '0;
            free_tail_q <= slot_t'(NUM_SLOTS - 1);
            free_cnt_q  <= 7'(NUM_SLOTS);
            w_ack_o     <= 1'b0;
            w_slot_o    <= '0;
            w_drop_o    <= 1'b0;
            r_valid_o   <= 1'b0;
            r_slot_o    <= '0;
            r_size_o    <= '0;
            r_empty_o   <= 1'b0;
        end else begin
            free_head_q <= free_head_d;
            free_tail_q <= free_tail_d;
            free_cnt_q  <= free_cnt_d;
            w_ack_o     <= alloc;
            w_drop_o    <= drop;
            r_valid_o   <= rd_ok;
            r_empty_o   <= rd_empty;
            if (alloc) begin
                w_slot_o <= free_head_q;
            end
            if (rd_ok) begin
                r_slot_o <= deq_head;
                r_size_o <= size_mem[deq_head];
            end
        end
    end

    assign free_cnt_o = free_cnt_q;
endmodule

// File: tb/tb_chain_manager.sv
// Directed self-checking bench for chain_manager.
module tb_chain_manager;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       wea_i;
    logic [7:0] w_size_i;
    logic [2:0] priority_i;
    logic [3:0] dest_port_i;
    logic       rea_i;
    logic [7:0] out_port_i;
    logic       w_ack_o;
    logic [5:0] w_slot_o;
    logic       w_drop_o;
    logic       r_valid_o;
    logic [5:0] r_slot_o;
    logic [7:0] r_size_o;
    logic       r_empty_o;
    logic [6:0] free_cnt_o;

    int n_checks = 0;
    int n_err    = 0;

    chain_manager dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wea_i       (wea_i),
        .w_size_i    (w_size_i),
        .priority_i  (priority_i),
        .dest_port_i (dest_port_i),
        .rea_i       (rea_i),
        .out_port_i  (out_port_i),
        .w_ack_o     (w_ack_o),
        .w_slot_o    (w_slot_o),
        .w_drop_o    (w_drop_o),
        .r_valid_o   (r_valid_o),
        .r_slot_o    (r_slot_o),
        .r_size_o    (r_size_o),
        .r_empty_o   (r_empty_o),
        .free_cnt_o  (free_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int q, input int size);
        wea_i       = 1'b1;
        w_size_i    = 8'(size);
        dest_port_i = 4'(q >> 3);
        priority_i  = 3'(q & 7);
    endtask

    task automatic set_rd(input logic [7:0] port);
        rea_i      = 1'b1;
        out_port_i = port;
    endtask

    task automatic set_idle;
        wea_i = 1'b0;
        rea_i = 1'b0;
    endtask

    int wq  [11] = '{0, 1, 8, 16, 2, 24, 25, 32, 40, 0, 1};
    int rq  [5]  = '{1, 16, 25, 40, 0};
    int rsl [5]  = '{1, 3, 6, 8, 9};
    int rsz [5]  = '{62, 66, 72, 76, 78};

    initial begin
        rst_i = 1'b1; wea_i = 1'b0; rea_i = 1'b0;
        w_size_i = '0; priority_i = '0; dest_port_i = '0; out_port_i = '0;
        tick; tick;
        rst_i = 1'b0;
        chk("rst_free_cnt", free_cnt_o, 64);
        chk("rst_w_ack", w_ack_o, 0);
        chk("rst_w_drop", w_drop_o, 0);
        chk("rst_w_slot", w_slot_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_empty", r_empty_o, 0);
        chk("rst_r_slot", r_slot_o, 0);
        chk("rst_r_size", r_size_o, 0);

        set_rd(8'd5); tick; set_idle;
        chk("rd_q5_empty", r_empty_o, 1);
        chk("rd_q5_valid", r_valid_o, 0);

        // 11 writes on alternate cycles; the last one overlaps the first read
        for (int i = 0; i < 11; i++) begin
            set_wr(wq[i], 60 + 2 * i);
            if (i == 10) set_rd(8'd0);
            tick;
            chk("wr_ack", w_ack_o, 1);
            chk("wr_slot", w_slot_o, 32'(i));
            if (i == 10) begin
                chk("rd0_valid", r_valid_o, 1);
                chk("rd0_slot", r_slot_o, 0);
                chk("rd0_size", r_size_o, 60);
                chk("rd0_free_cnt", free_cnt_o, 54);
            end
            set_idle; tick;
        end
        chk("wr_ack_pulse", w_ack_o, 0);
        chk("wr_slot_hold", w_slot_o, 10);

        for (int i = 0; i < 5; i++) begin
            set_rd(8'(rq[i])); tick; set_idle;
            chk("rd_valid", r_valid_o, 1);
            chk("rd_slot", r_slot_o, 32'(rsl[i]));
            chk("rd_size", r_size_o, 32'(rsz[i]));
            tick;
        end
        chk("rd_free_cnt", free_cnt_o, 59);
        set_rd(8'd1); tick; set_idle;
        chk("rd_q1_slot", r_slot_o, 10);
        chk("rd_q1_size", r_size_o, 80);
        set_rd(8'd1); tick; set_idle;
        chk("rd_q1_empty", r_empty_o, 1);
        chk("rd_q1_slot_hold", r_slot_o, 10);
        chk("free_cnt_60", free_cnt_o, 60);

        // mid-operation reset discards queues
        rst_i = 1'b1; set_wr(2, 5); set_rd(8'd8); tick; rst_i = 1'b0; set_idle;
        chk("rst2_free_cnt", free_cnt_o, 64);
        chk("rst2_w_ack", w_ack_o, 0);
        set_rd(8'd8); tick; set_idle;
        chk("rst2_q8_empty", r_empty_o, 1);

        // exhaust the pool back-to-back into queue 3
        for (int i = 0; i < 64; i++) begin
            set_wr(3, i); tick;
            chk("ex_ack", w_ack_o, 1);
            chk("ex_slot", w_slot_o, 32'(i));
        end
        chk("ex_free_cnt", free_cnt_o, 0);
        set_wr(3, 99); tick;
        chk("ex_drop", w_drop_o, 1);
        chk("ex_drop_ack", w_ack_o, 0);

        set_wr(7, 200); set_rd(8'd3); tick;
        chk("rw_drop", w_drop_o, 1);
        chk("rw_valid", r_valid_o, 1);
        chk("rw_slot", r_slot_o, 0);
        chk("rw_size", r_size_o, 0);
        chk("rw_free_cnt", free_cnt_o, 1);
        set_idle; set_wr(7, 201); tick;
        chk("reuse_ack", w_ack_o, 1);
        chk("reuse_slot", w_slot_o, 0);
        chk("reuse_free_cnt", free_cnt_o, 0);

        set_idle; set_rd(8'd3); tick;
        chk("q3_slot1", r_slot_o, 1);
        // last free slot taken while another is freed
        set_wr(9, 50); tick;
        chk("last_r_slot", r_slot_o, 2);
        chk("last_w_slot", w_slot_o, 1);
        chk("last_free_cnt", free_cnt_o, 1);
        set_idle; set_wr(9, 51); tick;
        chk("last_next_slot", w_slot_o, 2);
        chk("last_next_free", free_cnt_o, 0);

        set_idle; set_rd(8'd3); tick;
        chk("q3_slot3", r_slot_o, 3);
        chk("q3_size3", r_size_o, 3);

        // same-queue read and write on a 1-entry queue
        set_wr(7, 99); set_rd(8'd7); tick; set_idle;
        chk("sq_valid", r_valid_o, 1);
        chk("sq_r_slot", r_slot_o, 0);
        chk("sq_r_size", r_size_o, 201);
        chk("sq_w_slot", w_slot_o, 3);
        chk("sq_free_cnt", free_cnt_o, 1);
        set_rd(8'd7); tick; set_idle;
        chk("sq_next_slot", r_slot_o, 3);
        chk("sq_next_size", r_size_o, 99);
        set_rd(8'd7); tick; set_idle;
        chk("sq_now_empty", r_empty_o, 1);

        set_rd(8'h83); tick; set_idle;
        chk("bit7_empty", r_empty_o, 1);
        chk("bit7_valid", r_valid_o, 0);
        chk("bit7_free_cnt", free_cnt_o, 2);
        set_rd(8'h80); tick; set_idle;
        chk("h80_empty", r_empty_o, 1);
        set_rd(8'h03); tick; set_idle;
        chk("q3_after_slot", r_slot_o, 4);
        chk("q3_after_size", r_size_o, 4);
        chk("q3_after_free", free_cnt_o, 3);
        tick;
        chk("idle_valid", r_valid_o, 0);
        chk("idle_empty", r_empty_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
